// File: rtl/cfu_6_ctrl_pkg.sv
// Shared types and constants for the degree-6 check-node controller.
// Messages are sign-magnitude: bit 3 is the sign, bits [2:0] the magnitude.
package cfu_6_ctrl_pkg;

  localparam int MSG_W  = 4;
  localparam int MAG_W  = 3;
  localparam int DEG    = 6;
  localparam int ADDR_W = 10;

  localparam logic [ADDR_W-1:0] ROW_NUM_DEF = 10'd267;
  localparam logic [MAG_W-1:0]  OFFSET_DEF  = 3'd0;
  localparam logic [ADDR_W-1:0] CNT_MAX     = 10'd1023;

  typedef logic [MSG_W-1:0] msg_t;
  typedef msg_t [DEG-1:0]   msg_vec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } cfu_state_t;

  function automatic logic sign_parity(input msg_vec_t v);
    logic p;
    p = 1'b0;
    for (int i = 0; i < DEG; i++) begin
      p = p ^ v[i][MSG_W-1];
    end
    return p;
  endfunction

  function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 10'd1;
  endfunction

endpackage

// File: rtl/cfu_6_ctrl_if.sv
// RAM-side bus of the check-node controller: row address, enables and
// the six read/write message lanes.
interface cfu_6_ctrl_if;
  import cfu_6_ctrl_pkg::*;

  logic [ADDR_W-1:0] CFU_addr;
  logic              CFU_re_en;
  logic              CFU_wr_en;
  msg_t              ram_CFU_data_1, ram_CFU_data_2, ram_CFU_data_3;
  msg_t              ram_CFU_data_4, ram_CFU_data_5, ram_CFU_data_6;
  msg_t              CFU_data_1, CFU_data_2, CFU_data_3;
  msg_t              CFU_data_4, CFU_data_5, CFU_data_6;

  modport master (
    output CFU_addr, CFU_re_en, CFU_wr_en,
    output CFU_data_1, CFU_data_2, CFU_data_3,
    output CFU_data_4, CFU_data_5, CFU_data_6,
    input  ram_CFU_data_1, ram_CFU_data_2, ram_CFU_data_3,
    input  ram_CFU_data_4, ram_CFU_data_5, ram_CFU_data_6
  );

  modport slave (
    input  CFU_addr, CFU_re_en, CFU_wr_en,
    input  CFU_data_1, CFU_data_2, CFU_data_3,
    input  CFU_data_4, CFU_data_5, CFU_data_6,
    output ram_CFU_data_1, ram_CFU_data_2, ram_CFU_data_3,
    output ram_CFU_data_4, ram_CFU_data_5, ram_CFU_data_6
  );
endinterface

// File: rtl/cfu_6_ctrl_cn6.sv
// Combinational offset min-sum check-node core: six messages in, six
// extrinsic messages out, plus the row sign parity.
module cfu_6_ctrl_cn6
  import cfu_6_ctrl_pkg::*;
#(
  parameter logic [MAG_W-1:0] OFFSET = OFFSET_DEF
) (
  input  msg_vec_t msg_in,
  output msg_vec_t msg_out,
  output logic     parity
);

  logic [MAG_W-1:0] min1_s;
  logic [MAG_W-1:0] min2_s;
  logic [2:0]       idx_s;
  logic [MAG_W-1:0] mag_s;
  logic [MAG_W-1:0] sel_s;

  // Track the two smallest magnitudes; strict compare keeps the lowest index on ties.
  always_comb begin
    min1_s = 3'd7;
    min2_s = 3'd7;
    idx_s  = 3'd0;
    mag_s  = 3'd0;
    for (int i = 0; i < DEG; i++) begin
      mag_s = msg_in[i][MAG_W-1:0];
      if (mag_s < min1_s) begin
        min2_s = min1_s;
        min1_s = mag_s;
        idx_s  = 3'(i);
      end else if (mag_s < min2_s) begin
        min2_s = mag_s;
      end else begin
        min2_s = min2_s;
      end
    end
  end

  // Each lane takes min2 if it owns min1, otherwise min1, minus the floored offset.
  always_comb begin
    parity  = sign_parity(msg_in);
    msg_out = '0;
    sel_s   = 3'd0;
    for (int i = 0; i < DEG; i++) begin
      if (idx_s == 3'(i)) begin
        sel_s = min2_s;
      end else begin
        sel_s = min1_s;
      end
      if (sel_s > OFFSET) begin
        msg_out[i] = {parity ^ msg_in[i][MSG_W-1], sel_s - OFFSET};
      end else begin
        msg_out[i] = {parity ^ msg_in[i][MSG_W-1], 3'd0};
      end
    end
  end

endmodule

// File: rtl/cfu_6_ctrl.sv
// Check-node pass controller: alternates read/write phases over ROW_NUM rows,
// writes back min-sum messages and reports the unsatisfied-check count.
module cfu_6_ctrl
  import cfu_6_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ROW_NUM = ROW_NUM_DEF,
  parameter logic [MAG_W-1:0]  OFFSET  = OFFSET_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              flag_CFU_start,
  cfu_6_ctrl_if.master      ram_bus,
  output logic              flag_CFU_end,
  output logic [ADDR_W-1:0] err_row_cnt,
  output logic              syndrome_ok
);

  cfu_state_t        state_r;
  cfu_state_t        state_s;
  logic              CFU_en_s;
  logic              cnt_rd_wr_s;
  logic              last_wr_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] err_cnt_r;
  logic [ADDR_W-1:0] err_cnt_next_s;
  logic              flag_end_r;
  logic [ADDR_W-1:0] err_row_cnt_r;
  logic              syndrome_ok_r;
  logic              parity_s;
  msg_vec_t          msg_in_s;
  msg_vec_t          msg_out_s;

  assign msg_in_s = {ram_bus.ram_CFU_data_6, ram_bus.ram_CFU_data_5, ram_bus.ram_CFU_data_4,
                     ram_bus.ram_CFU_data_3, ram_bus.ram_CFU_data_2, ram_bus.ram_CFU_data_1};

  cfu_6_ctrl_cn6 #(.OFFSET(OFFSET)) u_cn6 (
    .msg_in  (msg_in_s),
    .msg_out (msg_out_s),
    .parity  (parity_s)
  );

  assign last_wr_s      = (state_r == ST_WRITE) && (addr_r == ROW_NUM - 10'd1);
  assign err_cnt_next_s = parity_s ? sat_inc(err_cnt_r) : err_cnt_r;

  // Phase state register; reset drops the enables asynchronously.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next phase: a start pulse always wins, even over the final write.
  always_comb begin
    state_s = state_r;
    if (flag_CFU_start) begin
      state_s = ST_READ;
    end else begin
      case (state_r)
        ST_IDLE:  state_s = ST_IDLE;
        ST_READ:  state_s = ST_WRITE;
        ST_WRITE: state_s = last_wr_s ? ST_IDLE : ST_READ;
        default:  state_s = ST_IDLE;
      endcase
    end
  end

  // Decode enable and read/write phase from the state.
  always_comb begin
    CFU_en_s    = 1'b0;
    cnt_rd_wr_s = 1'b0;
    case (state_r)
      ST_IDLE:  begin CFU_en_s = 1'b0; cnt_rd_wr_s = 1'b0; end
      ST_READ:  begin CFU_en_s = 1'b1; cnt_rd_wr_s = 1'b0; end
      ST_WRITE: begin CFU_en_s = 1'b1; cnt_rd_wr_s = 1'b1; end
      default:  begin CFU_en_s = 1'b0; cnt_rd_wr_s = 1'b0; end
    endcase
  end

  // Row address advances after every write phase and wraps after the last row.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      addr_r <= 10'd0;
    end else if (flag_CFU_start) begin
      addr_r <= 10'd0;
    end else if (state_r == ST_WRITE) begin
      addr_r <= last_wr_s ? 10'd0 : addr_r + 10'd1;
    end else begin
      addr_r <= addr_r;
    end
  end

  // Running unsatisfied-check count, sampled on write phases.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err_cnt_r <= 10'd0;
    end else if (flag_CFU_start) begin
      err_cnt_r <= 10'd0;
    end else if (state_r == ST_WRITE) begin
      err_cnt_r <= err_cnt_next_s;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  // Pass results load with the end pulse so they are valid in that same cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      flag_end_r    <= 1'b0;
      err_row_cnt_r <= 10'd0;
      syndrome_ok_r <= 1'b0;
    end else if (flag_CFU_start) begin
      flag_end_r    <= 1'b0;
      err_row_cnt_r <= 10'd0;
      syndrome_ok_r <= 1'b0;
    end else if (last_wr_s) begin
      flag_end_r    <= 1'b1;
      err_row_cnt_r <= err_cnt_next_s;
      syndrome_ok_r <= (err_cnt_next_s == 10'd0);
    end else begin
      flag_end_r    <= 1'b0;
      err_row_cnt_r <= err_row_cnt_r;
      syndrome_ok_r <= syndrome_ok_r;
    end
  end

  assign ram_bus.CFU_addr   = addr_r;
  assign ram_bus.CFU_re_en  = CFU_en_s & ~cnt_rd_wr_s;
  assign ram_bus.CFU_wr_en  = CFU_en_s & cnt_rd_wr_s;
  assign ram_bus.CFU_data_1 = msg_out_s[0];
  assign ram_bus.CFU_data_2 = msg_out_s[1];
  assign ram_bus.CFU_data_3 = msg_out_s[2];
  assign ram_bus.CFU_data_4 = msg_out_s[3];
  assign ram_bus.CFU_data_5 = msg_out_s[4];
  assign ram_bus.CFU_data_6 = msg_out_s[5];

  assign flag_CFU_end = flag_end_r;
  assign err_row_cnt  = err_row_cnt_r;
  assign syndrome_ok  = syndrome_ok_r;

endmodule
